// File: rtl/vote_result.sv
// vote_result: snapshots the four candidate tallies when result mode is
// entered, scans them one per clock to find the winner and any tie on the
// maximum, then cycles the display through each candidate's snapshot count.
module vote_result #(
    parameter int W     = 8,
    parameter int DWELL = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mode,
    input  logic [W-1:0] count1,
    input  logic [W-1:0] count2,
    input  logic [W-1:0] count3,
    input  logic [W-1:0] count4,
    output logic         busy,
    output logic         result_valid,
    output logic [1:0]   winner,
    output logic         tie,
    output logic [1:0]   disp_id,
    output logic [W-1:0] disp_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Last dwell count before the display moves to the next candidate.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t state;
    state_t state_next;

    logic                mode_q;
    logic                rise;
    logic [3:0][W-1:0]   snap;
    logic [3:0][W-1:0]   snap_next;
    logic [W-1:0]        best;
    logic [W-1:0]        best_next;
    logic [1:0]          idx;
    logic [1:0]          idx_next;
    logic [7:0]          dwell;
    logic [7:0]          dwell_next;
    logic [1:0]          next_disp_id;

    logic                busy_next;
    logic                result_valid_next;
    logic [1:0]          winner_next;
    logic                tie_next;
    logic [1:0]          disp_id_next;
    logic [W-1:0]        disp_count_next;

    // A scan is launched only by a 0->1 transition of mode relative to the
    // registered copy, so holding mode high through reset still starts one.
    assign rise         = mode && !mode_q;
    assign next_disp_id = disp_id + 2'd1;

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; dropping mode abandons any scan or display.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!mode) begin
                    state_next = IDLE;
                end else if (idx == 2'd3) begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                if (!mode) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs and the scan/display datapath.
    always_comb begin
        snap_next         = snap;
        best_next         = best;
        idx_next          = idx;
        dwell_next        = dwell;
        busy_next         = busy;
        result_valid_next = result_valid;
        winner_next       = winner;
        tie_next          = tie;
        disp_id_next      = disp_id;
        disp_count_next   = disp_count;

        case (state)
            IDLE: begin
                busy_next         = 1'b0;
                result_valid_next = 1'b0;
                winner_next       = 2'd0;
                tie_next          = 1'b0;
                disp_id_next      = 2'd0;
                disp_count_next   = '0;
                dwell_next        = 8'd0;
                idx_next          = 2'd0;
                if (rise) begin
                    snap_next   = {count4, count3, count2, count1};
                    best_next   = count1;
                    winner_next = 2'd0;
                    tie_next    = 1'b0;
                    idx_next    = 2'd1;
                    busy_next   = 1'b1;
                end
            end

            SCAN: begin
                if (!mode) begin
                    busy_next         = 1'b0;
                    result_valid_next = 1'b0;
                    winner_next       = 2'd0;
                    tie_next          = 1'b0;
                    disp_id_next      = 2'd0;
                    disp_count_next   = '0;
                    dwell_next        = 8'd0;
                    idx_next          = 2'd0;
                    best_next         = '0;
                end else begin
                    if (snap[idx] > best) begin
                        best_next   = snap[idx];
                        winner_next = idx;
                        tie_next    = 1'b0;
                    end else if (snap[idx] == best) begin
                        tie_next = 1'b1;
                    end
                    idx_next = idx + 2'd1;
                    if (idx == 2'd3) begin
                        busy_next         = 1'b0;
                        result_valid_next = 1'b1;
                        disp_id_next      = 2'd0;
                        disp_count_next   = snap[0];
                        dwell_next        = 8'd0;
                    end
                end
            end

            SHOW: begin
                if (!mode) begin
                    busy_next         = 1'b0;
                    result_valid_next = 1'b0;
                    winner_next       = 2'd0;
                    tie_next          = 1'b0;
                    disp_id_next      = 2'd0;
                    disp_count_next   = '0;
                    dwell_next        = 8'd0;
                    idx_next          = 2'd0;
                    best_next         = '0;
                end else if (dwell == DWELL_LAST) begin
                    dwell_next      = 8'd0;
                    disp_id_next    = next_disp_id;
                    disp_count_next = snap[next_disp_id];
                end else begin
                    dwell_next = dwell + 8'd1;
                end
            end

            default: begin
                busy_next         = 1'b0;
                result_valid_next = 1'b0;
                winner_next       = 2'd0;
                tie_next          = 1'b0;
                disp_id_next      = 2'd0;
                disp_count_next   = '0;
                dwell_next        = 8'd0;
                idx_next          = 2'd0;
            end
        endcase
    end

    // Datapath and output registers; reset clears everything including the snapshot.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mode_q       <= 1'b0;
            snap         <= '0;
            best         <= '0;
            idx          <= 2'd0;
            dwell        <= 8'd0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner       <= 2'd0;
            tie          <= 1'b0;
            disp_id      <= 2'd0;
            disp_count   <= '0;
        end else begin
            mode_q       <= mode;
            snap         <= snap_next;
            best         <= best_next;
            idx          <= idx_next;
            dwell        <= dwell_next;
            busy         <= busy_next;
            result_valid <= result_valid_next;
            winner       <= winner_next;
            tie          <= tie_next;
            disp_id      <= disp_id_next;
            disp_count   <= disp_count_next;
        end
    end

endmodule

// File: tb/tb_vote_result.sv
// tb_vote_result: drives directed and random tallies/mode/reset sequences
// into vote_result and compares every output each clock with a reference
// model based on elapsed time since the snapshot.
module tb_vote_result;

    localparam int W     = 8;
    localparam int DWELL = 4;

    logic         clock;
    logic         reset;
    logic         mode;
    logic [W-1:0] count1;
    logic [W-1:0] count2;
    logic [W-1:0] count3;
    logic [W-1:0] count4;
    logic         busy;
    logic         result_valid;
    logic [1:0]   winner;
    logic         tie;
    logic [1:0]   disp_id;
    logic [W-1:0] disp_count;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: whether a result session is running, how many edges
    // have passed since the snapshot edge, and the snapshot-derived answers.
    bit           m_active = 1'b0;
    int           m_t      = 0;
    bit           m_prev   = 1'b0;
    int           m_snap [4];
    int           m_win    = 0;
    bit           m_tie    = 1'b0;

    vote_result #(.W(W), .DWELL(DWELL)) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .count1       (count1),
        .count2       (count2),
        .count3       (count3),
        .count4       (count4),
        .busy         (busy),
        .result_valid (result_valid),
        .winner       (winner),
        .tie          (tie),
        .disp_id      (disp_id),
        .disp_count   (disp_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Snapshot the tallies and find the maximum, the first index holding it,
    // and how many candidates share it.
    task automatic modelSnapshot();
        int mx;
        int hits;
        m_snap[0] = int'(count1);
        m_snap[1] = int'(count2);
        m_snap[2] = int'(count3);
        m_snap[3] = int'(count4);
        mx = m_snap[0];
        for (int i = 1; i < 4; i++) if (m_snap[i] > mx) mx = m_snap[i];
        m_win = -1;
        hits  = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_snap[i] == mx) begin
                hits++;
                if (m_win < 0) m_win = i;
            end
        end
        m_tie = (hits > 1);
    endtask

    // Advance the model by one rising edge using the inputs held at that edge.
    task automatic modelEdge();
        if (!reset) begin
            m_active = 1'b0;
            m_prev   = 1'b0;
        end else begin
            if (!m_active) begin
                if (mode && !m_prev) begin
                    m_active = 1'b1;
                    m_t      = 0;
                    modelSnapshot();
                end
            end else if (!mode) begin
                m_active = 1'b0;
            end else begin
                m_t++;
            end
            m_prev = mode;
        end
    endtask

    task automatic checkAll();
        int id;
        if (!m_active) begin
            checkOutput("idle_busy",  32'(busy),         32'd0);
            checkOutput("idle_valid", 32'(result_valid), 32'd0);
            checkOutput("idle_winner",32'(winner),       32'd0);
            checkOutput("idle_tie",   32'(tie),          32'd0);
            checkOutput("idle_id",    32'(disp_id),      32'd0);
            checkOutput("idle_count", 32'(disp_count),   32'd0);
        end else if (m_t < 3) begin
            checkOutput("scan_busy",  32'(busy),         32'd1);
            checkOutput("scan_valid", 32'(result_valid), 32'd0);
        end else begin
            id = ((m_t - 3) / DWELL) % 4;
            checkOutput("show_busy",  32'(busy),         32'd0);
            checkOutput("show_valid", 32'(result_valid), 32'd1);
            checkOutput("show_winner",32'(winner),       32'(m_win));
            checkOutput("show_tie",   32'(tie),          32'(m_tie));
            checkOutput("show_id",    32'(disp_id),      32'(id));
            checkOutput("show_count", 32'(disp_count),   32'(m_snap[id]));
        end
    endtask

    // Hold the given inputs for a number of clocks, checking after every edge.
    task automatic applyStimulus(input logic r, input logic m,
                                 input logic [W-1:0] c1, input logic [W-1:0] c2,
                                 input logic [W-1:0] c3, input logic [W-1:0] c4,
                                 input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clock);
            reset  = r;
            mode   = m;
            count1 = c1;
            count2 = c2;
            count3 = c3;
            count4 = c4;
            @(posedge clock);
            modelEdge();
            #1;
            checkAll();
        end
    endtask

    initial begin
        logic [W-1:0] rc [4];
        logic         rm;
        logic         rr;
        int           hold;

        reset  = 1'b0;
        mode   = 1'b0;
        count1 = '0;
        count2 = '0;
        count3 = '0;
        count4 = '0;

        // Reset state.
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 3);
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 2);

        // Clear winner, then scan/show timing.
        applyStimulus(1'b1, 1'b1, 8'd3, 8'd9, 8'd5, 8'd2, 3 + 4 * DWELL + 2);
        applyStimulus(1'b1, 1'b0, 8'd3, 8'd9, 8'd5, 8'd2, 2);

        // Tie handling, including a tie cleared by a later greater count.
        applyStimulus(1'b1, 1'b1, 8'd7, 8'd2, 8'd7, 8'd7, 6);
        applyStimulus(1'b1, 1'b0, 8'd7, 8'd2, 8'd7, 8'd7, 1);
        applyStimulus(1'b1, 1'b1, 8'd4, 8'd8, 8'd8, 8'd1, 6);
        applyStimulus(1'b1, 1'b0, 8'd4, 8'd8, 8'd8, 8'd1, 1);
        applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 6);
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1);
        applyStimulus(1'b1, 1'b1, 8'd8, 8'd8, 8'd9, 8'd0, 6);
        applyStimulus(1'b1, 1'b0, 8'd8, 8'd8, 8'd9, 8'd0, 1);

        // Display rotation with wrap, and tally changes ignored after snapshot.
        applyStimulus(1'b1, 1'b1, 8'd10, 8'd20, 8'd30, 8'd40, 3 + 4 * DWELL + 2);
        applyStimulus(1'b1, 1'b1, 8'd10, 8'd99, 8'd30, 8'd40, 4 * DWELL);
        applyStimulus(1'b1, 1'b0, 8'd10, 8'd99, 8'd30, 8'd40, 1);

        // Abort mid-scan, then a fresh scan.
        applyStimulus(1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 2);
        applyStimulus(1'b1, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 2);
        applyStimulus(1'b1, 1'b1, 8'd6, 8'd5, 8'd4, 8'd3, 8);

        // Reset during display with mode held high restarts a scan.
        applyStimulus(1'b0, 1'b1, 8'd6, 8'd5, 8'd4, 8'd3, 1);
        applyStimulus(1'b1, 1'b1, 8'd2, 8'd12, 8'd12, 8'd1, 8);
        applyStimulus(1'b1, 1'b0, 8'd2, 8'd12, 8'd12, 8'd1, 1);

        // Full-scale tallies.
        applyStimulus(1'b1, 1'b1, 8'd255, 8'd254, 8'd255, 8'd0, 3 + 4 * DWELL + 1);
        applyStimulus(1'b1, 1'b0, 8'd255, 8'd254, 8'd255, 8'd0, 1);

        // Random sessions; narrow-range tallies make ties frequent.
        for (int it = 0; it < 250; it++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 1) == 0) rc[c] = 8'($urandom_range(0, 3));
                else                           rc[c] = 8'($urandom);
            end
            rm   = ($urandom_range(0, 3) != 0);
            rr   = ($urandom_range(0, 19) != 0);
            hold = rr ? int'($urandom_range(1, 24)) : 1;
            applyStimulus(rr, rm, rc[0], rc[1], rc[2], rc[3], hold);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
